// File: rtl/fifo_axis_master_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream bridge.
//   DATA_W        : beat payload width
//   QUEUE_DEPTH   : number of output-queue entries
//   OCC_W         : width of the queue occupancy count (holds 0..QUEUE_DEPTH)
//   PKT_CNT_W_DEF : default width of the completed-packet counter
//   beat_t        : one queued beat {tlast, data}
package fifo_axis_pkg;

    localparam int DATA_W        = 8;
    localparam int QUEUE_DEPTH   = 3;
    localparam int OCC_W         = $clog2(QUEUE_DEPTH + 1);
    localparam int PKT_CNT_W_DEF = 16;

    typedef struct packed {
        logic              tlast;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/fifo_axis_master_if.sv
// Bundle of the FIFO read port and the AXI-Stream master port.
//   master modport : the bridge (reads the FIFO, drives the stream)
//   slave  modport : the environment (FIFO read side + stream sink)
//   fifo_data/fifo_tlast : FIFO read data, valid the cycle after fifo_re_en
//   fifo_empty           : FIFO empty flag
//   fifo_re_en           : FIFO read enable
//   m_axis_*             : AXI-Stream master channel
interface fifo_axis_master_if;
    import fifo_axis_pkg::*;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_tlast;
    logic              fifo_empty;
    logic              fifo_re_en;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    modport master (
        input  fifo_data, fifo_tlast, fifo_empty, m_axis_tready,
        output fifo_re_en, m_axis_tdata, m_axis_tlast, m_axis_tvalid
    );

    modport slave (
        output fifo_data, fifo_tlast, fifo_empty, m_axis_tready,
        input  fifo_re_en, m_axis_tdata, m_axis_tlast, m_axis_tvalid
    );

endinterface

// File: rtl/fifo_axis_master_queue.sv
// Small register queue holding beats between the FIFO and the stream port.
// Entry 0 is always the head; a pop shifts every entry down by one, and a
// push writes at the first free slot (after the shift when both happen).
//   clk, srst : clock, synchronous active-high reset
//   i_push    : write i_beat at the tail this cycle
//   i_beat    : beat to write
//   i_pop     : remove the head this cycle (caller guarantees o_occ != 0)
//   o_head    : current head entry
//   o_occ     : number of valid entries
module axis_out_queue
    import fifo_axis_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  beat_t            i_beat,
    input  logic             i_pop,
    output beat_t            o_head,
    output logic [OCC_W-1:0] o_occ
);

    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_m1;
    beat_t            w_entry [QUEUE_DEPTH];

    assign w_occ_m1 = r_occ - 1'b1;

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : gen_entry
            localparam logic [OCC_W-1:0] IDX = OCC_W'(gi);
            beat_t r_beat;
            beat_t w_shift;

            // Value this slot takes when the queue shifts down; the top slot
            // has no neighbour and simply keeps its (now unused) contents.
            if (gi < QUEUE_DEPTH - 1) begin : gen_mid
                assign w_shift = w_entry[gi+1];
            end else begin : gen_top
                assign w_shift = r_beat;
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    r_beat <= '0;
                end else if (i_pop) begin
                    // With a pop, the tail slot after shifting is occ-1.
                    if (i_push && (w_occ_m1 == IDX)) begin
                        r_beat <= i_beat;
                    end else begin
                        r_beat <= w_shift;
                    end
                end else if (i_push && (r_occ == IDX)) begin
                    r_beat <= i_beat;
                end
            end

            assign w_entry[gi] = r_beat;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            r_occ <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = w_entry[0];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_axis_master.sv
// Reads beats from a first-word-fall-through-less FIFO (data one cycle after
// the read strobe) and presents them on an AXI-Stream master port at up to
// one beat per cycle, counting completed packets.
//   aclk      : clock
//   areset    : synchronous active-high reset
//   bus       : FIFO read port + AXIS master channel (master modport)
//   pkt_count : number of handshakes with tlast, wraps at all-ones
//   busy      : a beat is queued or a FIFO read is in flight
module fifo_axis_master
    import fifo_axis_pkg::*;
#(
    parameter int PKT_CNT_W = PKT_CNT_W_DEF
) (
    input  logic                 aclk,
    input  logic                 areset,
    fifo_axis_master_if.master   bus,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 busy
);

    logic                 r_rd_pending;
    logic [PKT_CNT_W-1:0] r_pkt_count;
    logic [OCC_W-1:0]     w_occ;
    logic [OCC_W:0]       w_inflight;
    logic                 w_re_en;
    logic                 w_push;
    logic                 w_pop;
    beat_t                w_in_beat;
    beat_t                w_head;

    // Issue a read only if the queue can absorb it together with a read
    // already in flight, assuming nothing drains. This keeps the read path
    // independent of tready while still sustaining one beat per cycle.
    assign w_inflight = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_rd_pending};
    assign w_re_en    = !areset && !bus.fifo_empty && (w_inflight <= (OCC_W+1)'(QUEUE_DEPTH - 1));

    // FIFO outputs are meaningful only in the cycle after a read strobe.
    assign w_push    = r_rd_pending;
    assign w_in_beat = beat_t'({bus.fifo_tlast, bus.fifo_data});
    assign w_pop     = bus.m_axis_tvalid && bus.m_axis_tready;

    axis_out_queue u_queue (
        .clk    (aclk),
        .srst   (areset),
        .i_push (w_push),
        .i_beat (w_in_beat),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_pending <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_rd_pending <= w_re_en;
            if (w_pop && w_head.tlast) begin
                r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
            end
        end
    end

    assign bus.fifo_re_en    = w_re_en;
    assign bus.m_axis_tvalid = (w_occ != '0);
    assign bus.m_axis_tdata  = w_head.data;
    assign bus.m_axis_tlast  = w_head.tlast;
    assign pkt_count         = r_pkt_count;
    assign busy              = (w_occ != '0) || r_rd_pending;

endmodule

// File: tb/tb_fifo_axis_master.sv
// Directed bench for fifo_axis_master. A behavioural upstream FIFO feeds the
// bridge; every beat written into it is also pushed to an expected queue and
// popped/compared when the bridge hands it over on the stream port.
module tb_fifo_axis_master;
    import fifo_axis_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic [CW-1:0] pkt_count;
    logic          busy;

    fifo_axis_master_if bus ();

    fifo_axis_master #(.PKT_CNT_W(CW)) dut (
        .aclk      (clk),
        .areset    (areset),
        .bus       (bus),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [8:0]    src_q [$];
    logic [8:0]    exp_q [$];
    logic [CW-1:0] m_pkts;
    logic          s_re_en, s_tvalid, s_tlast, s_busy;
    logic [7:0]    s_tdata;
    logic [CW-1:0] s_pkt;
    logic          prev_stall;
    logic [7:0]    prev_tdata;
    logic          prev_tlast;
    logic          tv_h [4];
    logic          re_h [4];
    logic          bz_h [4];
    logic [CW-1:0] pk_h [4];
    int            n_v, first_v, last_v, k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l);
        src_q.push_back({l, d});
        exp_q.push_back({l, d});
    endtask

    // One clock cycle: called #1 after a rising edge. Samples the DUT at the
    // falling edge, scores any handshake, then models the FIFO read.
    task automatic step();
        logic [8:0] b;
        bus.fifo_empty = (src_q.size() == 0);
        @(negedge clk);
        s_re_en  = bus.fifo_re_en;
        s_tvalid = bus.m_axis_tvalid;
        s_tdata  = bus.m_axis_tdata;
        s_tlast  = bus.m_axis_tlast;
        s_busy   = busy;
        s_pkt    = pkt_count;
        check("pkt_count", s_pkt, m_pkts);
        if (prev_stall) begin
            check("hold_tdata", s_tdata, prev_tdata);
            check("hold_tlast", s_tlast, prev_tlast);
        end
        if (s_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", exp_q.size(), 1);
            end else begin
                b = exp_q.pop_front();
                check("tdata", s_tdata, b[7:0]);
                check("tlast", s_tlast, b[8]);
                if (b[8]) m_pkts = m_pkts + 1'b1;
            end
        end
        prev_stall = s_tvalid && !bus.m_axis_tready;
        prev_tdata = s_tdata;
        prev_tlast = s_tlast;
        @(posedge clk);
        #1;
        if (s_re_en) begin
            if (src_q.size() > 0) begin
                b = src_q.pop_front();
                bus.fifo_data  = b[7:0];
                bus.fifo_tlast = b[8];
            end else begin
                check("read_while_empty", src_q.size(), 1);
            end
        end else begin
            // Garbage outside the valid read-data cycle must be ignored.
            bus.fifo_data  = 8'($urandom);
            bus.fifo_tlast = 1'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        areset = 1'b1;
        bus.m_axis_tready = 1'b0;
        bus.fifo_empty = (src_q.size() == 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("re_en_in_reset", bus.fifo_re_en, 1'b0);
            @(posedge clk);
            #1;
        end
        areset = 1'b0;
        src_q.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        m_pkts = '0;
        prev_stall = 1'b0;
        #1;
        check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, 8'h00);
        check("rst_tlast", bus.m_axis_tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_count", pkt_count, '0);
        check("rst_re_en", bus.fifo_re_en, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        int c = 0;
        while (exp_q.size() > 0 && c < max) begin
            step();
            c++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        areset = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = 8'h00;
        bus.fifo_tlast = 1'b0;
        bus.m_axis_tready = 1'b0;
        m_pkts = '0;
        prev_stall = 1'b0;
        prev_tdata = 8'h00;
        prev_tlast = 1'b0;
        do_reset(2);

        // Single beat: read in cycle 0, valid in cycle 2, idle in cycle 3.
        bus.m_axis_tready = 1'b1;
        push_beat(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            tv_h[i] = s_tvalid;
            re_h[i] = s_re_en;
            bz_h[i] = s_busy;
            pk_h[i] = s_pkt;
        end
        check("single_re_en_c0", re_h[0], 1'b1);
        check("single_re_en_c1", re_h[1], 1'b0);
        check("single_tvalid_c0", tv_h[0], 1'b0);
        check("single_tvalid_c1", tv_h[1], 1'b0);
        check("single_tvalid_c2", tv_h[2], 1'b1);
        check("single_tvalid_c3", tv_h[3], 1'b0);
        check("single_busy_c2", bz_h[2], 1'b1);
        check("single_busy_c3", bz_h[3], 1'b0);
        check("single_pkt_c2", pk_h[2], 4'd0);
        check("single_pkt_c3", pk_h[3], 4'd1);
        check("single_drained", exp_q.size(), 0);

        // Streaming: 16 beats back to back.
        do_reset(1);
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(8'(i), i == 15);
        n_v = 0; first_v = -1; last_v = -1; k = 0;
        while (exp_q.size() > 0 && k < 60) begin
            step();
            if (s_tvalid) begin
                n_v++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            k++;
        end
        check("stream_drained", exp_q.size(), 0);
        check("stream_valid_cycles", n_v, 16);
        check("stream_span", last_v - first_v + 1, 16);
        step();
        check("stream_pkt_count", s_pkt, 4'd1);

        // Backpressure: stall 10 cycles, queue fills to 3, reads stop.
        do_reset(1);
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) push_beat(8'h40 + 8'(i), i == 19);
        repeat (10) step();
        check("bp_occ_full", dut.w_occ, 2'd3);
        check("bp_re_en_off", s_re_en, 1'b0);
        check("bp_busy", s_busy, 1'b1);
        check("bp_tvalid", s_tvalid, 1'b1);
        check("bp_head", s_tdata, 8'h40);
        bus.m_axis_tready = 1'b1;
        drain("bp_drained", 100);
        step();
        check("bp_pkt_count", s_pkt, 4'd1);

        // Random tready over 1000 beats.
        do_reset(1);
        for (int i = 0; i < 1000; i++) push_beat(8'($urandom), $urandom_range(0, 7) == 0);
        k = 0;
        while (exp_q.size() > 0 && k < 6000) begin
            bus.m_axis_tready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        check("rand_drained", exp_q.size(), 0);

        // Packet counter wrap with a 4-bit counter: 17 packets -> 1.
        do_reset(1);
        bus.m_axis_tready = 1'b1;
        for (int p = 0; p < 17; p++) push_beat(8'(p), 1'b1);
        drain("wrap_drained", 100);
        step();
        check("wrap_pkt_count", s_pkt, 4'd1);

        // Reset mid-stream with two beats queued and a read in flight.
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) push_beat(8'hC0 + 8'(i), i == 5);
        repeat (3) step();
        check("mid_occ", dut.w_occ, 2'd2);
        check("mid_rd_pending", dut.r_rd_pending, 1'b1);
        do_reset(1);
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_stale_tvalid", s_tvalid, 1'b0);
            check("no_stale_busy", s_busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_axis_master.md
FIFO_AXIS_MASTER -- requirements
Module: fifo_axis_master

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: aclk input 1 clock; areset input 1 reset (synchronous, active-high).
REQ-002 The block SHALL have parameter PKT_CNT_W, default 16, giving the width of the packet counter.
REQ-003 The block SHALL have port fifo_data, input, 8 bits: FIFO read data, valid the cycle after fifo_re_en.
REQ-004 The block SHALL have port fifo_tlast, input, 1 bit: FIFO read tlast, same timing as fifo_data.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 The block SHALL have port fifo_re_en, output, 1 bit: FIFO read enable.
REQ-007 The block SHALL have port m_axis_tdata, output, 8 bits: AXIS master data.
REQ-008 The block SHALL have port m_axis_tlast, output, 1 bit: AXIS master end-of-packet.
REQ-009 The block SHALL have port m_axis_tvalid, output, 1 bit: AXIS master valid.
REQ-010 The block SHALL have port m_axis_tready, input, 1 bit: AXIS slave ready.
REQ-011 The block SHALL have port pkt_count, output, PKT_CNT_W bits: count of completed packets.
REQ-012 The block SHALL have port busy, output, 1 bit: set when a beat is held in the queue or a read is in flight.

Function
REQ-013 Internal state SHALL be: a 3-entry beat queue {data, tlast}; 2-bit occupancy occ (0..3); 1-bit rd_pending (read issued last cycle).
REQ-014 fifo_re_en SHALL equal !fifo_empty && (occ + rd_pending) <= 2, with no combinational path from m_axis_tready.
REQ-015 rd_pending SHALL register fifo_re_en every cycle.
REQ-016 When rd_pending=1, {fifo_data, fifo_tlast} SHALL be written at the queue tail on that clock edge; on any other cycle the FIFO outputs SHALL be ignored.
REQ-017 m_axis_tvalid SHALL equal (occ != 0); m_axis_tdata and m_axis_tlast SHALL present the queue head.
REQ-018 A handshake (tvalid && tready) SHALL pop the head.
REQ-019 Simultaneous push and pop SHALL leave occ unchanged and preserve beat order.
REQ-020 While tvalid=1 and tready=0, tdata and tlast SHALL be held stable.
REQ-021 First-beat latency SHALL be 2 cycles: fifo_empty falls in cycle N, re_en in N, data captured at the end of N+1, tvalid=1 in N+2.
REQ-022 Steady-state throughput SHALL be 1 beat/cycle when the FIFO is non-empty and tready=1.
REQ-023 occ SHALL never exceed 3, and no beat SHALL be dropped or duplicated under any tready pattern.
REQ-024 pkt_count SHALL increment by 1 on each handshake with m_axis_tlast=1 and SHALL wrap from all-ones to 0.
REQ-025 busy SHALL equal (occ != 0) || rd_pending.

Reset
REQ-026 On areset=1 at a clock edge, the block SHALL clear occ=0 and rd_pending=0, and drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_count=0, busy=0, fifo_re_en=0.
REQ-027 Reset mid-operation SHALL discard queued and in-flight beats; the FIFO is reset in the same cycle by the system.
REQ-028 fifo_re_en SHALL be forced to 0 while areset=1.

Structure
REQ-029 Package fifo_axis_pkg SHALL hold DATA_W=8, QUEUE_DEPTH=3, the occupancy width (2), and the default PKT_CNT_W=16.
REQ-030 The 3-entry register queue SHALL be one sub-module, axis_out_queue (push, pop, head, occ); the read-issue logic and pkt_count SHALL stay in the top module.

Verification
REQ-031 Single beat: FIFO holds 0xA5 with tlast=1, tready=1 -> re_en in cycle 0, tvalid in cycle 2 with tdata=0xA5, tlast=1; pkt_count 0->1; busy=0 in cycle 3.
REQ-032 Streaming: 16 beats 0x00..0x0F, tlast on 0x0F, tready=1 -> 16 consecutive valid cycles in order; pkt_count=1.
REQ-033 Backpressure: tready=0 for 10 cycles with the FIFO non-empty -> occ=3, re_en=0, tdata held stable; tready=1 -> remaining beats in order, none lost.
REQ-034 Random tready (50%) over 1000 beats -> scoreboard matches the FIFO write order exactly; occ<=3 always.
REQ-035 Wrap: PKT_CNT_W=4, 17 single-beat packets -> pkt_count reads 1 after the 17th packet.
REQ-036 Reset mid-stream with occ=2 and rd_pending=1 -> next cycle tvalid=0, busy=0, pkt_count=0; no stale beat is emitted after reset.
